// File: rtl/game_master_fsm_multi_torpedo.sv
// Game master for the target/torpedo game with N_TORPEDOES torpedoes.
// It fires torpedoes on key presses, tracks score and lives, and sequences rounds.
module game_master_fsm_multi_torpedo #(
  parameter int N_TORPEDOES = 3,
  parameter int N_LIVES     = 3,
  parameter int LIVES_W     = 2,
  parameter int SCORE_W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key,
  output logic                   sprite_target_write_xy,
  output logic                   sprite_target_write_dxy,
  output logic                   sprite_target_enable_update,
  input  logic                   sprite_target_within_screen,
  output logic [N_TORPEDOES-1:0] sprite_torpedo_write_xy,
  output logic [N_TORPEDOES-1:0] sprite_torpedo_write_dxy,
  output logic [N_TORPEDOES-1:0] sprite_torpedo_enable_update,
  input  logic [N_TORPEDOES-1:0] sprite_torpedo_within_screen,
  input  logic [N_TORPEDOES-1:0] collision,
  output logic                   end_of_game_timer_start,
  input  logic                   end_of_game_timer_running,
  output logic                   game_won,
  output logic                   game_over,
  output logic [SCORE_W-1:0]     score,
  output logic [LIVES_W-1:0]     lives
);

  typedef enum logic [2:0] {
    START,
    PLAY,
    WON,
    WON_END,
    LOST,
    LOST_END,
    OVER
  } state_t;

  state_t                 state, n_state;
  logic                   key_r;
  logic                   init;
  logic [N_TORPEDOES-1:0] fired, active;
  logic [N_TORPEDOES-1:0] n_fired, n_active;
  logic [N_TORPEDOES-1:0] launch_sel;
  logic                   found;
  logic                   key_edge;
  logic                   hit;

  logic                   n_target_write_xy;
  logic                   n_target_write_dxy;
  logic                   n_target_enable_update;
  logic [N_TORPEDOES-1:0] n_torpedo_write_xy;
  logic [N_TORPEDOES-1:0] n_torpedo_write_dxy;
  logic [N_TORPEDOES-1:0] n_torpedo_enable_update;
  logic                   n_timer_start;

  always_comb begin
    key_edge   = key & ~key_r;
    hit        = |(collision & active);
    n_state    = state;
    n_fired    = fired;
    n_active   = active;
    launch_sel = '0;
    found      = 1'b0;

    case (state)
      START: begin
        n_fired  = '0;
        n_active = '0;
        // The START reached straight out of reset is held one extra cycle so
        // that it gets the same sprite-load strobes as any later START.
        if (!init) n_state = PLAY;
      end
      PLAY: begin
        n_active = active & sprite_torpedo_within_screen;
        if (hit) begin
          n_state = WON;
        end else if (!sprite_target_within_screen) begin
          n_state = LOST;
        end else if ((&fired) && !(|active)) begin
          n_state = LOST;
        end else if (key_edge) begin
          for (int unsigned i = 0; i < N_TORPEDOES; i++) begin
            if (!fired[i] && !found) begin
              launch_sel[i] = 1'b1;
              found         = 1'b1;
            end
          end
          n_fired  = fired | launch_sel;
          n_active = n_active | launch_sel;
        end
      end
      WON:      n_state = WON_END;
      WON_END:  if (!end_of_game_timer_running) n_state = START;
      LOST:     n_state = LOST_END;
      LOST_END: begin
        if (!end_of_game_timer_running) n_state = (lives == '0) ? OVER : START;
      end
      OVER:     if (key_edge) n_state = START;
      default:  n_state = START;
    endcase

    n_target_write_xy       = (n_state == START) && ((state != START) || init);
    n_target_write_dxy      = n_target_write_xy;
    n_torpedo_write_xy      = n_target_write_xy ? '1 : '0;
    n_target_enable_update  = (n_state == PLAY);
    n_torpedo_enable_update = (n_state == PLAY) ? n_active : '0;
    n_torpedo_write_dxy     = launch_sel;
    n_timer_start           = ((n_state == WON) && (state != WON)) ||
                              ((n_state == LOST) && (state != LOST));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= START;
      key_r  <= 1'b0;
      init   <= 1'b1;
      fired  <= '0;
      active <= '0;
    end else begin
      state  <= n_state;
      key_r  <= key;
      init   <= 1'b0;
      fired  <= n_fired;
      active <= n_active;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score <= '0;
      lives <= LIVES_W'(N_LIVES);
    end else begin
      if (state == WON && score != '1) score <= score + 1'b1;
      if (state == LOST) lives <= lives - 1'b1;
      if (state == OVER && key_edge) begin
        score <= '0;
        lives <= LIVES_W'(N_LIVES);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sprite_target_write_xy       <= 1'b0;
      sprite_target_write_dxy      <= 1'b0;
      sprite_target_enable_update  <= 1'b0;
      sprite_torpedo_write_xy      <= '0;
      sprite_torpedo_write_dxy     <= '0;
      sprite_torpedo_enable_update <= '0;
      end_of_game_timer_start      <= 1'b0;
    end else begin
      sprite_target_write_xy       <= n_target_write_xy;
      sprite_target_write_dxy      <= n_target_write_dxy;
      sprite_target_enable_update  <= n_target_enable_update;
      sprite_torpedo_write_xy      <= n_torpedo_write_xy;
      sprite_torpedo_write_dxy     <= n_torpedo_write_dxy;
      sprite_torpedo_enable_update <= n_torpedo_enable_update;
      end_of_game_timer_start      <= n_timer_start;
    end
  end

  assign game_won  = (state == WON) || (state == WON_END);
  assign game_over = (state == OVER);

endmodule

// File: tb/tb_game_master_fsm_multi_torpedo.sv
// Bench for game_master_fsm_multi_torpedo: table of {inputs, expected outputs}
// rows plus hand sequences, checked through an expected-value queue.
module tb_game_master_fsm_multi_torpedo;

  typedef struct packed {
    logic       t_wxy, t_wdxy, t_en;
    logic [2:0] p_wxy, p_wdxy, p_en;
    logic       tstart, won, over;
    logic [7:0] score;
    logic [1:0] lives;
  } out_t;

  typedef struct packed {
    logic       key, tgt;
    logic [2:0] trp, coll;
    logic       tmr;
  } in_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       key;
  logic       sprite_target_write_xy, sprite_target_write_dxy, sprite_target_enable_update;
  logic       sprite_target_within_screen;
  logic [2:0] sprite_torpedo_write_xy, sprite_torpedo_write_dxy, sprite_torpedo_enable_update;
  logic [2:0] sprite_torpedo_within_screen, collision;
  logic       end_of_game_timer_start, end_of_game_timer_running;
  logic       game_won, game_over;
  logic [7:0] score;
  logic [1:0] lives;

  out_t got;
  out_t exp_q[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   row   = 0;

  game_master_fsm_multi_torpedo #(
    .N_TORPEDOES(3),
    .N_LIVES    (3),
    .LIVES_W    (2),
    .SCORE_W    (8)
  ) dut (
    .clk                          (clk),
    .reset                        (reset),
    .key                          (key),
    .sprite_target_write_xy       (sprite_target_write_xy),
    .sprite_target_write_dxy      (sprite_target_write_dxy),
    .sprite_target_enable_update  (sprite_target_enable_update),
    .sprite_target_within_screen  (sprite_target_within_screen),
    .sprite_torpedo_write_xy      (sprite_torpedo_write_xy),
    .sprite_torpedo_write_dxy     (sprite_torpedo_write_dxy),
    .sprite_torpedo_enable_update (sprite_torpedo_enable_update),
    .sprite_torpedo_within_screen (sprite_torpedo_within_screen),
    .collision                    (collision),
    .end_of_game_timer_start      (end_of_game_timer_start),
    .end_of_game_timer_running    (end_of_game_timer_running),
    .game_won                     (game_won),
    .game_over                    (game_over),
    .score                        (score),
    .lives                        (lives)
  );

  always #5 clk = ~clk;

  assign got = {sprite_target_write_xy, sprite_target_write_dxy, sprite_target_enable_update,
                sprite_torpedo_write_xy, sprite_torpedo_write_dxy, sprite_torpedo_enable_update,
                end_of_game_timer_start, game_won, game_over, score, lives};

  function automatic in_t ii(logic k, logic [2:0] c, logic [2:0] trp, logic tgt, logic tmr);
    in_t v;
    v.key = k; v.coll = c; v.trp = trp; v.tgt = tgt; v.tmr = tmr;
    return v;
  endfunction

  function automatic out_t o_start(logic [7:0] sc, logic [1:0] lv);
    out_t v = '0;
    v.t_wxy = 1'b1; v.t_wdxy = 1'b1; v.p_wxy = 3'b111;
    v.score = sc; v.lives = lv;
    return v;
  endfunction

  function automatic out_t o_play(logic [2:0] dxy, logic [2:0] en, logic [7:0] sc, logic [1:0] lv);
    out_t v = '0;
    v.t_en = 1'b1; v.p_wdxy = dxy; v.p_en = en;
    v.score = sc; v.lives = lv;
    return v;
  endfunction

  function automatic out_t o_q(logic ts, logic wn, logic ov, logic [7:0] sc, logic [1:0] lv);
    out_t v = '0;
    v.tstart = ts; v.won = wn; v.over = ov;
    v.score = sc; v.lives = lv;
    return v;
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i; v.o = o;
    tbl.push_back(v);
  endtask

  task automatic drive(input in_t i);
    key                          = i.key;
    collision                    = i.coll;
    sprite_torpedo_within_screen = i.trp;
    sprite_target_within_screen  = i.tgt;
    end_of_game_timer_running    = i.tmr;
  endtask

  task automatic check(input string tag);
    out_t e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s #%0d: scoreboard empty", tag, row);
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL %s #%0d: got %h expected %h", tag, row, got, e);
      end
    end
    row++;
  endtask

  task automatic step(input in_t i, input out_t e, input string tag);
    drive(i);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] sc;
    reset = 1'b0;
    drive(ii(0, 3'b000, 3'b111, 1, 0));
    #12;
    exp_q.push_back(o_q(0, 0, 0, 8'd0, 2'd3));
    check("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    add(ii(0, 3'b000, 3'b111, 1, 0), o_start(0, 3));          // 0 initial START strobes
    add(ii(0, 3'b000, 3'b111, 1, 0), o_play(3'b000, 3'b000, 0, 3));
    add(ii(1, 3'b000, 3'b111, 1, 0), o_play(3'b001, 3'b001, 0, 3));
    add(ii(1, 3'b000, 3'b111, 1, 0), o_play(3'b000, 3'b001, 0, 3));
    add(ii(0, 3'b000, 3'b111, 1, 0), o_play(3'b000, 3'b001, 0, 3));
    add(ii(1, 3'b000, 3'b111, 1, 0), o_play(3'b010, 3'b011, 0, 3));
    add(ii(0, 3'b000, 3'b111, 1, 0), o_play(3'b000, 3'b011, 0, 3));
    add(ii(1, 3'b000, 3'b111, 1, 0), o_play(3'b100, 3'b111, 0, 3));
    add(ii(0, 3'b000, 3'b111, 1, 0), o_play(3'b000, 3'b111, 0, 3));
    add(ii(1, 3'b000, 3'b111, 1, 0), o_play(3'b000, 3'b111, 0, 3)); // 4th press ignored
    add(ii(0, 3'b010, 3'b111, 1, 0), o_q(1, 1, 0, 0, 3));            // 10 hit -> WON
    add(ii(0, 3'b000, 3'b111, 1, 1), o_q(0, 1, 0, 1, 3));
    add(ii(0, 3'b000, 3'b111, 1, 1), o_q(0, 1, 0, 1, 3));
    add(ii(0, 3'b000, 3'b111, 1, 0), o_start(1, 3));
    add(ii(0, 3'b000, 3'b111, 1, 0), o_play(3'b000, 3'b000, 1, 3));
    add(ii(1, 3'b000, 3'b111, 1, 0), o_play(3'b001, 3'b001, 1, 3)); // 15 spend all torpedoes
    add(ii(0, 3'b000, 3'b110, 1, 0), o_play(3'b000, 3'b000, 1, 3));
    add(ii(1, 3'b000, 3'b111, 1, 0), o_play(3'b010, 3'b010, 1, 3));
    add(ii(0, 3'b000, 3'b101, 1, 0), o_play(3'b000, 3'b000, 1, 3));
    add(ii(1, 3'b000, 3'b111, 1, 0), o_play(3'b100, 3'b100, 1, 3));
    add(ii(0, 3'b000, 3'b011, 1, 0), o_play(3'b000, 3'b000, 1, 3));
    add(ii(0, 3'b000, 3'b111, 1, 0), o_q(1, 0, 0, 1, 3));            // 21 spent -> LOST
    add(ii(0, 3'b000, 3'b111, 1, 1), o_q(0, 0, 0, 1, 2));
    add(ii(0, 3'b000, 3'b111, 1, 0), o_start(1, 2));
    add(ii(0, 3'b000, 3'b111, 1, 0), o_play(3'b000, 3'b000, 1, 2));
    add(ii(0, 3'b000, 3'b111, 0, 0), o_q(1, 0, 0, 1, 2));            // 25 target off screen
    add(ii(0, 3'b000, 3'b111, 1, 0), o_q(0, 0, 0, 1, 1));
    add(ii(0, 3'b000, 3'b111, 1, 0), o_start(1, 1));
    add(ii(0, 3'b000, 3'b111, 1, 0), o_play(3'b000, 3'b000, 1, 1));
    add(ii(0, 3'b000, 3'b111, 0, 0), o_q(1, 0, 0, 1, 1));
    add(ii(0, 3'b000, 3'b111, 1, 0), o_q(0, 0, 0, 1, 0));
    add(ii(0, 3'b000, 3'b111, 1, 1), o_q(0, 0, 0, 1, 0));
    add(ii(0, 3'b000, 3'b111, 1, 0), o_q(0, 0, 1, 1, 0));            // 32 OVER
    add(ii(0, 3'b000, 3'b111, 1, 0), o_q(0, 0, 1, 1, 0));
    add(ii(1, 3'b000, 3'b111, 1, 0), o_start(0, 3));                 // 34 restart
    add(ii(1, 3'b000, 3'b111, 1, 0), o_play(3'b000, 3'b000, 0, 3));
    add(ii(0, 3'b000, 3'b111, 1, 0), o_play(3'b000, 3'b000, 0, 3));
    add(ii(1, 3'b000, 3'b111, 1, 0), o_play(3'b001, 3'b001, 0, 3));
    add(ii(0, 3'b000, 3'b111, 1, 0), o_play(3'b000, 3'b001, 0, 3));
    add(ii(1, 3'b001, 3'b111, 1, 0), o_q(1, 1, 0, 0, 3));            // 39 key edge + hit
    add(ii(0, 3'b000, 3'b111, 1, 0), o_q(0, 1, 0, 1, 3));
    add(ii(0, 3'b000, 3'b111, 1, 0), o_start(1, 3));
    add(ii(0, 3'b000, 3'b111, 1, 0), o_play(3'b000, 3'b000, 1, 3));
    add(ii(0, 3'b010, 3'b111, 1, 0), o_play(3'b000, 3'b000, 1, 3)); // 43 inactive collision
    add(ii(1, 3'b010, 3'b111, 1, 0), o_play(3'b001, 3'b001, 1, 3));
    add(ii(0, 3'b000, 3'b111, 1, 0), o_play(3'b000, 3'b001, 1, 3));
    add(ii(0, 3'b001, 3'b111, 1, 0), o_q(1, 1, 0, 1, 3));
    add(ii(0, 3'b000, 3'b111, 1, 0), o_q(0, 1, 0, 2, 3));
    add(ii(0, 3'b000, 3'b111, 1, 0), o_start(2, 3));
    add(ii(0, 3'b000, 3'b111, 1, 0), o_play(3'b000, 3'b000, 2, 3));

    for (int n = 0; n < tbl.size(); n++) step(tbl[n].i, tbl[n].o, "table");

    // Score saturation: repeated wins, more than enough to pass 8'hFF.
    sc = 8'd2;
    for (int r = 0; r < 256; r++) begin
      step(ii(1, 3'b000, 3'b111, 1, 0), o_play(3'b001, 3'b001, sc, 3), "sat_launch");
      step(ii(0, 3'b001, 3'b111, 1, 0), o_q(1, 1, 0, sc, 3), "sat_won");
      sc = (sc == 8'hFF) ? 8'hFF : sc + 8'd1;
      step(ii(0, 3'b000, 3'b111, 1, 0), o_q(0, 1, 0, sc, 3), "sat_score");
      step(ii(0, 3'b000, 3'b111, 1, 0), o_start(sc, 3), "sat_start");
      step(ii(0, 3'b000, 3'b111, 1, 0), o_play(3'b000, 3'b000, sc, 3), "sat_play");
    end

    // Asynchronous reset in the middle of PLAY with a torpedo in flight.
    step(ii(1, 3'b000, 3'b111, 1, 0), o_play(3'b001, 3'b001, 8'hFF, 3), "pre_reset");
    #3;
    reset = 1'b0;
    #1;
    exp_q.push_back(o_q(0, 0, 0, 8'd0, 2'd3));
    check("mid_reset");
    drive(ii(0, 3'b000, 3'b111, 1, 1));
    @(posedge clk); #1;
    exp_q.push_back(o_q(0, 0, 0, 8'd0, 2'd3));
    check("reset_held");
    reset = 1'b1;
    step(ii(0, 3'b000, 3'b111, 1, 1), o_start(0, 3), "post_reset_start");
    step(ii(0, 3'b000, 3'b111, 1, 1), o_play(3'b000, 3'b000, 0, 3), "post_reset_play");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
